hazard_unit: RTL and testbench

- Hazard/forwarding controller for the 5-stage MIPS pipeline datapath; it is the control-side counterpart of the datapath's hazard interface.
- Consumes the datapath's register-index and write-enable taps and returns stalF, stalD, flushE, flushD, forwardAE and forwardBE.
- Keeps internal shadow copies of the E-stage source index (RsE) and W-stage write info, because the datapath does not export them.
- Adds a stall watchdog and an observable state register.

---
 rtl/hazard_pkg.sv | 17 +
 rtl/hazard_unit_if.sv | 51 +++++
 rtl/hazard_fwd_sel.sv | 27 ++
 rtl/hazard_unit.sv | 153 +++++++++++++++
 tb/tb_hazard_unit.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the MIPS pipeline hazard/forwarding controller.
// Optional performance counters are enabled with HAZARD_PERF_CNT_EN.
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        BRFLUSH = 2'd2
    } hz_state_t;

endpackage

// File: rtl/hazard_unit_if.sv
// Datapath <-> hazard controller bundle: register-index taps in, pipeline controls out.
// Perf-counter outputs exist only when HAZARD_PERF_CNT_EN is defined.
interface hazard_unit_if #(
    parameter int REG_W = 5
);
    logic [REG_W-1:0] RsD;
    logic [REG_W-1:0] RtD;
    logic [REG_W-1:0] RtE;
    logic [REG_W-1:0] WriteRegE;
    logic [REG_W-1:0] WriteRegM;
    logic             RegWriteE;
    logic             RegWriteM;
    logic             LWE;
    logic             tontbE;

    logic             stalF;
    logic             stalD;
    logic             flushD;
    logic             flushE;
    logic [1:0]       forwardAE;
    logic [1:0]       forwardBE;
    logic [1:0]       hz_state;
    logic             stall_err;

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0]      perf_stall;
    logic [15:0]      perf_flush;
    logic [15:0]      perf_fwd;

    modport master (
        output RsD, RtD, RtE, WriteRegE, WriteRegM, RegWriteE, RegWriteM, LWE, tontbE,
        input  stalF, stalD, flushD, flushE, forwardAE, forwardBE, hz_state, stall_err,
        input  perf_stall, perf_flush, perf_fwd
    );
    modport slave (
        input  RsD, RtD, RtE, WriteRegE, WriteRegM, RegWriteE, RegWriteM, LWE, tontbE,
        output stalF, stalD, flushD, flushE, forwardAE, forwardBE, hz_state, stall_err,
        output perf_stall, perf_flush, perf_fwd
    );
`else
    modport master (
        output RsD, RtD, RtE, WriteRegE, WriteRegM, RegWriteE, RegWriteM, LWE, tontbE,
        input  stalF, stalD, flushD, flushE, forwardAE, forwardBE, hz_state, stall_err
    );
    modport slave (
        input  RsD, RtD, RtE, WriteRegE, WriteRegM, RegWriteE, RegWriteM, LWE, tontbE,
        output stalF, stalD, flushD, flushE, forwardAE, forwardBE, hz_state, stall_err
    );
`endif

endinterface

// File: rtl/hazard_fwd_sel.sv
// One forwarding-mux select: compares a source index against the M and W write-backs.
// M has priority because it holds the younger result; register $0 never forwards.
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] src_i,
    input  logic [REG_W-1:0] wr_m_i,
    input  logic             we_m_i,
    input  logic [REG_W-1:0] wr_w_i,
    input  logic             we_w_i,
    output logic [1:0]       sel_o
);

    localparam logic [REG_W-1:0] ZERO = REG_W'(REG_ZERO);

    always_comb begin
        sel_o = FWD_RF;
        if (we_m_i && (wr_m_i != ZERO) && (wr_m_i == src_i)) begin
            sel_o = FWD_MEM;
        end else if (we_w_i && (wr_w_i != ZERO) && (wr_w_i == src_i)) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Hazard/forwarding controller for the 5-stage MIPS pipeline, with stall watchdog.
// Optional saturating perf counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int MAX_STALL = 4,
    parameter int REG_W     = 5
) (
    input  logic         clk,
    input  logic         reset,
    hazard_unit_if.slave hz
);

    localparam int               CNT_W = $clog2(MAX_STALL + 1);
    localparam logic [REG_W-1:0] ZERO  = REG_W'(REG_ZERO);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_STALL);

    // Shadow copies of ID/EX rs and MEM/WB write info the datapath keeps private
    logic [REG_W-1:0] RsE_q, RsE_d;
    logic [REG_W-1:0] WriteRegW_q;
    logic             RegWriteW_q;

    logic             lwstall;
    logic [1:0]       fwd_a, fwd_b;
    logic             stall_s, flushD_s, flushE_s;

    hz_state_t        state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             stall_err_q, stall_err_d;

    logic             diag_unused;

    assign diag_unused = ^{hz.WriteRegE, hz.RegWriteE};

    hazard_fwd_sel #(.REG_W(REG_W)) u_fwd_a (
        .src_i  (RsE_q),
        .wr_m_i (hz.WriteRegM),
        .we_m_i (hz.RegWriteM),
        .wr_w_i (WriteRegW_q),
        .we_w_i (RegWriteW_q),
        .sel_o  (fwd_a)
    );

    hazard_fwd_sel #(.REG_W(REG_W)) u_fwd_b (
        .src_i  (hz.RtE),
        .wr_m_i (hz.WriteRegM),
        .we_m_i (hz.RegWriteM),
        .wr_w_i (WriteRegW_q),
        .we_w_i (RegWriteW_q),
        .sel_o  (fwd_b)
    );

    assign lwstall = hz.LWE && (hz.RtE != ZERO) &&
                     ((hz.RtE == hz.RsD) || (hz.RtE == hz.RtD));

    // Controls are combinational, but held inactive while reset is asserted
    always_comb begin
        stall_s      = 1'b0;
        flushD_s     = 1'b0;
        flushE_s     = 1'b0;
        hz.forwardAE = FWD_RF;
        hz.forwardBE = FWD_RF;
        if (reset) begin
            stall_s      = lwstall && !hz.tontbE;
            flushD_s     = hz.tontbE;
            flushE_s     = lwstall || hz.tontbE;
            hz.forwardAE = fwd_a;
            hz.forwardBE = fwd_b;
        end
    end

    assign hz.stalF     = stall_s;
    assign hz.stalD     = stall_s;
    assign hz.flushD    = flushD_s;
    assign hz.flushE    = flushE_s;
    assign hz.hz_state  = state_q;
    assign hz.stall_err = stall_err_q;

    assign RsE_d = flushE_s ? ZERO : hz.RsD;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            RsE_q       <= '0;
            RegWriteW_q <= 1'b0;
            WriteRegW_q <= '0;
        end else begin
            RsE_q       <= RsE_d;
            RegWriteW_q <= hz.RegWriteM;
            WriteRegW_q <= hz.WriteRegM;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state depends only on this cycle's event; any stray encoding falls back to RUN
    always_comb begin
        state_d = RUN;
        if (hz.tontbE) begin
            state_d = BRFLUSH;
        end else if (lwstall) begin
            state_d = LDSTALL;
        end
    end

    always_comb begin
        stall_cnt_d = '0;
        if (stall_s) begin
            stall_cnt_d = (stall_cnt_q == CNT_MAX) ? stall_cnt_q : stall_cnt_q + CNT_W'(1);
        end
        stall_err_d = stall_err_q || (stall_cnt_d == CNT_MAX);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            stall_err_q <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            stall_err_q <= stall_err_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
        return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

    logic [15:0] perf_stall_q, perf_flush_q, perf_fwd_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
            perf_fwd_q   <= '0;
        end else begin
            perf_stall_q <= sat_inc16(perf_stall_q, lwstall);
            perf_flush_q <= sat_inc16(perf_flush_q, hz.tontbE);
            perf_fwd_q   <= sat_inc16(perf_fwd_q, (fwd_a != FWD_RF) || (fwd_b != FWD_RF));
        end
    end

    assign hz.perf_stall = perf_stall_q;
    assign hz.perf_flush = perf_flush_q;
    assign hz.perf_fwd   = perf_fwd_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit (MAX_STALL=4, REG_W=5).
// Perf-counter checks are compiled in only with HAZARD_PERF_CNT_EN.
module tb_hazard_unit;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    hazard_unit_if #(.REG_W(5)) hz_if ();

    hazard_unit #(.MAX_STALL(4), .REG_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ctrl(input string tag, input logic sf, input logic sd,
                        input logic fd, input logic fe);
        check({tag, ".stalF"},  16'(hz_if.stalF),  16'(sf));
        check({tag, ".stalD"},  16'(hz_if.stalD),  16'(sd));
        check({tag, ".flushD"}, 16'(hz_if.flushD), 16'(fd));
        check({tag, ".flushE"}, 16'(hz_if.flushE), 16'(fe));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        hz_if.RsD       = '0;
        hz_if.RtD       = '0;
        hz_if.RtE       = '0;
        hz_if.WriteRegE = '0;
        hz_if.WriteRegM = '0;
        hz_if.RegWriteE = 1'b0;
        hz_if.RegWriteM = 1'b0;
        hz_if.LWE       = 1'b0;
        hz_if.tontbE    = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        #2;
        check("rst.hz_state",  16'(hz_if.hz_state),  16'd0);
        check("rst.stall_err", 16'(hz_if.stall_err), 16'd0);
        ctrl("rst", 1'b0, 1'b0, 1'b0, 1'b0);

        // Hazard inputs present during reset must not leak to the outputs
        hz_if.LWE = 1'b1; hz_if.RtE = 5'd2; hz_if.RsD = 5'd2; hz_if.tontbE = 1'b1;
        #1;
        ctrl("rst_forced", 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_forced.fwdB", 16'(hz_if.forwardBE), 16'd0);
        tick();
        check("rst_hold.hz_state", 16'(hz_if.hz_state), 16'd0);
        clear_inputs();
        reset = 1'b1;

        // Forwarding A from M then from W
        hz_if.RsD = 5'd3;
        tick();
        hz_if.RegWriteM = 1'b1; hz_if.WriteRegM = 5'd3;
        #1;
        check("fwdA.mem", 16'(hz_if.forwardAE), 16'd2);
        check("fwdB.none", 16'(hz_if.forwardBE), 16'd0);
        tick();
        hz_if.RegWriteM = 1'b0;
        #1;
        check("fwdA.wb", 16'(hz_if.forwardAE), 16'd1);

        // M beats W on the same register
        hz_if.RegWriteM = 1'b1; hz_if.WriteRegM = 5'd5;
        tick();
        hz_if.RtE = 5'd5;
        #1;
        check("fwdB.mem_prio", 16'(hz_if.forwardBE), 16'd2);
        check("fwdA.no_match", 16'(hz_if.forwardAE), 16'd0);
        hz_if.RegWriteM = 1'b0;
        #1;
        check("fwdB.wb", 16'(hz_if.forwardBE), 16'd1);

        // Writes to $0 never forward
        hz_if.RegWriteM = 1'b1; hz_if.WriteRegM = 5'd0; hz_if.RsD = 5'd0;
        tick();
        hz_if.RtE = 5'd0;
        #1;
        check("fwdB.zero", 16'(hz_if.forwardBE), 16'd0);
        check("fwdA.zero", 16'(hz_if.forwardAE), 16'd0);
        check("run.hz_state", 16'(hz_if.hz_state), 16'd0);

        // Load-use stall
        clear_inputs();
        tick();
        hz_if.LWE = 1'b1; hz_if.RtE = 5'd8; hz_if.RsD = 5'd8;
        #1;
        ctrl("lduse", 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        check("lduse.hz_state", 16'(hz_if.hz_state), 16'd1);
        hz_if.RtE = 5'd0;
        #1;
        ctrl("lduse_r0", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("lduse_r0.hz_state", 16'(hz_if.hz_state), 16'd0);

        // Taken branch with a simultaneous load-use
        clear_inputs();
        hz_if.tontbE = 1'b1; hz_if.LWE = 1'b1; hz_if.RtE = 5'd4; hz_if.RtD = 5'd4;
        #1;
        ctrl("br_lduse", 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        check("br.hz_state", 16'(hz_if.hz_state), 16'd2);
        clear_inputs();
        tick();
        check("br_after.hz_state", 16'(hz_if.hz_state), 16'd0);

        // Watchdog trips on the 4th consecutive stall and is sticky
        hz_if.LWE = 1'b1; hz_if.RtE = 5'd2; hz_if.RsD = 5'd2;
        tick(); tick(); tick();
        check("wdog.3", 16'(hz_if.stall_err), 16'd0);
        tick();
        check("wdog.4", 16'(hz_if.stall_err), 16'd1);
        clear_inputs();
        tick();
        check("wdog.sticky", 16'(hz_if.stall_err), 16'd1);
        reset = 1'b0;
        #1;
        check("wdog.rst_clear", 16'(hz_if.stall_err), 16'd0);
        reset = 1'b1;

        // Reset in the middle of a stall run restarts the count
        hz_if.LWE = 1'b1; hz_if.RtE = 5'd2; hz_if.RsD = 5'd2;
        tick(); tick(); tick();
        reset = 1'b0;
        #1;
        reset = 1'b1;
        tick(); tick(); tick();
        check("wdog.restart3", 16'(hz_if.stall_err), 16'd0);
        tick();
        check("wdog.restart4", 16'(hz_if.stall_err), 16'd1);
        clear_inputs();

`ifdef HAZARD_PERF_CNT_EN
        reset = 1'b0;
        #1;
        reset = 1'b1;
        hz_if.LWE = 1'b1; hz_if.RtE = 5'd6; hz_if.RtD = 5'd6;
        tick(); tick(); tick();
        clear_inputs();
        hz_if.tontbE = 1'b1;
        tick(); tick();
        clear_inputs();
        tick();
        check("perf.stall", hz_if.perf_stall, 16'd3);
        check("perf.flush", hz_if.perf_flush, 16'd2);
        check("perf.fwd",   hz_if.perf_fwd,   16'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
